fifo_rd_ctrl: RTL and testbench
===============================

# fifo_rd_ctrl

Read-side controller for the dual-clock FIFO. It lives in the read (sync_clk) domain and consumes the Gray write pointer after it has passed through the 2-flop pointer synchronizer. It owns the read pointer, issues reads to the 1-cycle-latency FIFO RAM, and presents data on a valid/ready stream through a 2-entry output buffer. It also returns the registered Gray read pointer for synchronization into the write domain.

## Interface
- ADDR_WIDTH, 10, RAM address width; depth = 2^ADDR_WIDTH; pointers are ADDR_WIDTH+1 bits.
- DATA_WIDTH, 32, word width.
- AEMPTY_THRESH, 4, aempty asserted when rd_count <= this value.

- sync_clk  in  1  read-domain clock.
- rst_n  in  1  reset, asynchronous, active-low.
- wptr_gray_sync  in  ADDR_WIDTH+1  Gray write pointer, already synchronized to sync_clk.
- rptr_gray  out  ADDR_WIDTH+1  registered Gray read pointer, to the write-domain synchronizer.
- mem_ren  out  1  RAM read enable.
- mem_raddr  out  ADDR_WIDTH  RAM read address.
- mem_rdata  in  DATA_WIDTH  RAM read data, valid the cycle after mem_ren.
- m_valid  out  1  output word valid.
- m_ready  in  1  downstream accepts.
- m_data  out  DATA_WIDTH  output word.
- rd_count  out  ADDR_WIDTH+1  words in RAM not yet read (read-domain view).
- empty  out  1  rd_count == 0.
- aempty  out  1  rd_count <= AEMPTY_THRESH.

## Operation
- Pointer and count logic:
  - rbin is the binary read pointer.
  - wbin = gray-to-binary(wptr_gray_sync), combinational.
  - rd_count = wbin - rbin, modulo 2^(ADDR_WIDTH+1); range 0..2^ADDR_WIDTH.
  - rd_count, empty and aempty are combinational from flops only.
- Read address: mem_raddr = rbin[ADDR_WIDTH-1:0].
- Read pointer update: on mem_ren, rbin <= rbin+1 and rptr_gray <= (rbin+1) ^ ((rbin+1)>>1) at the same edge.
- Credit tracking:
  - buf_cnt (0..2) counts words held in the output buffer.
  - inflight (0/1) is a registered mem_ren.
  - occ = buf_cnt + inflight.
  - pop = m_valid & m_ready.
- Issue rule: mem_ren = !empty && (occ < 2 || (occ == 2 && pop)). mem_ren depends combinationally on m_ready; this is intended and gives full throughput.
- Output buffer: 2-entry in-order FIFO.
  - m_data is the head entry; m_valid = (buf_cnt != 0).
  - When inflight=1, mem_rdata is written at the tail (after a simultaneous pop).
  - The buffer never overflows, by the issue rule.
- m_data holds stable while m_valid && !m_ready.
- Stale wptr_gray_sync only under-reports rd_count. It may advance several steps per cycle; no read is ever issued beyond the true write pointer.
- Full RAM: rd_count = 2^ADDR_WIDTH (pointer MSBs differ, low bits equal). This is a legal input; reads proceed normally.
- Wrap-around: rbin wraps from all-ones to 0. mem_raddr wraps 2^ADDR_WIDTH-1 -> 0, and the rptr_gray MSB toggles.
- Reset (asynchronous, including mid-operation):
  - rbin=0, rptr_gray=0, buf_cnt=0, inflight=0, m_data=0.
  - Hence m_valid=0, mem_ren=0 (while wptr_gray_sync=0), rd_count=0, empty=1, aempty=1.
  - Any read in flight at reset is discarded. mem_rdata is ignored in the first cycle after reset release.
  - The write side must be reset in the same event.

## Timing
- wptr_gray_sync update at edge E0 (FIFO previously empty, occ=0):
  - mem_ren=1 during cycle E0..E1.
  - mem_rdata is captured at E2; m_valid=1 after E2.
  - Latency is 2 cycles from synchronized pointer to m_valid.
- Steady streaming with m_ready=1 and rd_count>0: one mem_ren and one pop per cycle, no bubbles.
- Backpressure: with m_ready=0, at most 2 reads are outstanding/buffered; mem_ren stays low once occ=2.
- Release of m_ready:
  - The pop and a new mem_ren occur in the same cycle.
  - The buffered second word appears on m_data the next cycle.
- rptr_gray reflects a read at the clock edge ending the mem_ren cycle.

## Test plan
- Reset: hold rst_n=0 with random inputs -> m_valid=0, m_data=0, rptr_gray=0, mem_ren=0, rd_count=0, empty=1, aempty=1.
- Single word: RAM[0]=0xA5A5_0001, wptr_gray_sync 0->1 at E0, m_ready=1 -> mem_ren=1 with mem_raddr=0 in cycle E0..E1; m_valid=1 with m_data=0xA5A5_0001 after E2 for one cycle; rptr_gray=1; empty=1 after E1.
- Streaming: wptr_gray_sync 0->24 (binary 16), m_ready=1 -> 16 consecutive mem_ren (addresses 0..15), then 16 back-to-back m_valid beats in address order, no gaps; rd_count ends at 0.
- Backpressure: 8 words available, m_ready=0 -> exactly 2 mem_ren, then mem_ren=0; rd_count=6; m_data stable at word 0. Then m_ready=1 -> words 0..7 delivered in order with no gaps after the first.
- Wrap and full (ADDR_WIDTH=3):
  - Stream 20 words -> mem_raddr wraps 7->0 twice; rptr_gray MSB toggles at reads 8 and 16; data order preserved.
  - Stall with wbin-rbin=8 -> rd_count=8, aempty=0.
- Reset mid-read: assert rst_n low for one cycle while inflight=1 and buf_cnt=1 -> m_valid drops immediately; rptr_gray=0. After release with wptr_gray_sync=0, no m_valid ever asserts and the returned mem_rdata is never presented.

Source files
------------

// File: rtl/fifo_rd_ctrl.sv
// Read-side controller of the dual-clock FIFO: owns the read pointer, issues
// 1-cycle-latency RAM reads and streams words out through a 2-entry buffer.
module fifo_rd_ctrl #(
    parameter int unsigned ADDR_WIDTH    = 10,
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned AEMPTY_THRESH = 4
) (
    input  logic                  sync_clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH:0]   wptr_gray_sync,
    output logic [ADDR_WIDTH:0]   rptr_gray,
    output logic                  mem_ren,
    output logic [ADDR_WIDTH-1:0] mem_raddr,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [ADDR_WIDTH:0]   rd_count,
    output logic                  empty,
    output logic                  aempty
);

    localparam int unsigned PW = ADDR_WIDTH + 1;

    logic [PW-1:0]         rbin;
    logic [PW-1:0]         rbin_nxt;
    logic [PW-1:0]         wbin;
    logic [1:0]            buf_cnt;
    logic                  inflight;
    logic [1:0]            occ;
    logic                  pop;
    logic [DATA_WIDTH-1:0] buf_q [2];

    // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it
    for (genvar i = 0; i < PW; i++) begin : g_g2b
        assign wbin[i] = ^wptr_gray_sync[PW-1:i];
    end

    assign rd_count = wbin - rbin;
    assign empty    = (rd_count == '0);
    assign aempty   = (rd_count <= PW'(AEMPTY_THRESH));

    assign occ      = buf_cnt + {1'b0, inflight};
    assign m_valid  = (buf_cnt != 2'd0);
    assign m_data   = buf_q[0];
    assign pop      = m_valid & m_ready;

    // A slot frees up in the same cycle as a pop, so issue against it for full rate
    assign mem_ren   = !empty && ((occ < 2'd2) || ((occ == 2'd2) && pop));
    assign mem_raddr = rbin[ADDR_WIDTH-1:0];
    assign rbin_nxt  = rbin + PW'(1);

    // Read pointer, binary and Gray copies advance together
    always_ff @(posedge sync_clk or negedge rst_n) begin
        if (!rst_n) begin
            rbin      <= '0;
            rptr_gray <= '0;
        end else if (mem_ren) begin
            rbin      <= rbin_nxt;
            rptr_gray <= rbin_nxt ^ (rbin_nxt >> 1);
        end
    end

    // Output buffer: in-order 2-entry FIFO, head in buf_q[0]
    always_ff @(posedge sync_clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight <= 1'b0;
            buf_cnt  <= 2'd0;
            buf_q[0] <= '0;
            buf_q[1] <= '0;
        end else begin
            inflight <= mem_ren;
            case ({pop, inflight})
                2'b10: begin
                    buf_q[0] <= buf_q[1];
                    buf_cnt  <= buf_cnt - 2'd1;
                end
                2'b01: begin
                    if (buf_cnt == 2'd0) begin
                        buf_q[0] <= mem_rdata;
                    end else begin
                        buf_q[1] <= mem_rdata;
                    end
                    buf_cnt <= buf_cnt + 2'd1;
                end
                2'b11: begin
                    if (buf_cnt == 2'd1) begin
                        buf_q[0] <= mem_rdata;
                    end else begin
                        buf_q[0] <= buf_q[1];
                        buf_q[1] <= mem_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Randomized bench for fifo_rd_ctrl against a word-counting reference model
// of the FIFO read side (written/synced/read/delivered counts plus a data queue).
module tb_fifo_rd_ctrl;

    localparam int unsigned AW = 4;
    localparam int unsigned DW = 32;
    localparam int unsigned TH = 4;
    localparam int unsigned D  = 1 << AW;
    localparam int unsigned PW = AW + 1;

    logic          sync_clk;
    logic          rst_n;
    logic [PW-1:0] wptr_gray_sync;
    logic [PW-1:0] rptr_gray;
    logic          mem_ren;
    logic [AW-1:0] mem_raddr;
    logic [DW-1:0] mem_rdata;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic [PW-1:0] rd_count;
    logic          empty;
    logic          aempty;

    fifo_rd_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .AEMPTY_THRESH(TH)) dut (
        .sync_clk       (sync_clk),
        .rst_n          (rst_n),
        .wptr_gray_sync (wptr_gray_sync),
        .rptr_gray      (rptr_gray),
        .mem_ren        (mem_ren),
        .mem_raddr      (mem_raddr),
        .mem_rdata      (mem_rdata),
        .m_valid        (m_valid),
        .m_ready        (m_ready),
        .m_data         (m_data),
        .rd_count       (rd_count),
        .empty          (empty),
        .aempty         (aempty)
    );

    initial sync_clk = 1'b0;
    always #5 sync_clk = ~sync_clk;

    // FIFO RAM with one cycle of read latency
    logic [DW-1:0] ram [D];
    initial mem_rdata = '0;
    always @(posedge sync_clk) begin
        if (mem_ren) mem_rdata <= ram[mem_raddr];
    end

    // Reference model: plain word counts since the last reset
    int unsigned   wtrue, wsync, issued, delivered, captured;
    bit            infl_m;
    logic [DW-1:0] data_q [$];
    int unsigned   n_vec, n_fail;

    function automatic logic [PW-1:0] gray(input int unsigned v);
        logic [PW-1:0] b;
        b = PW'(v);
        return b ^ (b >> 1);
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic push_val(input logic [DW-1:0] d);
        if (wtrue - issued < D) begin
            ram[wtrue % D] = d;
            data_q.push_back(d);
            wtrue++;
        end
    endtask

    task automatic push_rand(input int unsigned n);
        for (int i = 0; i < int'(n); i++) push_val($urandom);
    endtask

    task automatic model_reset();
        wtrue = 0; wsync = 0; issued = 0; delivered = 0; captured = 0;
        infl_m = 1'b0;
        data_q.delete();
    endtask

    // Called at a negedge with inputs chosen; checks, advances one clock
    task automatic tick();
        int unsigned avail, occ;
        bit ev, ep, er;
        wptr_gray_sync = gray(wsync);
        #1;
        avail = wsync - issued;
        occ   = issued - delivered;
        ev    = captured > delivered;
        ep    = ev && m_ready;
        er    = (avail > 0) && ((occ - int'(ep)) < 2);
        chk("m_valid", 64'(m_valid), 64'(ev));
        if (ev) chk("m_data", 64'(m_data), 64'(data_q[delivered]));
        chk("mem_ren", 64'(mem_ren), 64'(er));
        if (er) chk("mem_raddr", 64'(mem_raddr), 64'(issued % D));
        chk("rd_count", 64'(rd_count), 64'(avail));
        chk("empty", 64'(empty), 64'(avail == 0));
        chk("aempty", 64'(aempty), 64'(avail <= TH));
        chk("rptr_gray", 64'(rptr_gray), 64'(gray(issued)));
        @(posedge sync_clk);
        captured  += int'(infl_m);
        infl_m     = er;
        issued    += int'(er);
        delivered += int'(ep);
        @(negedge sync_clk);
    endtask

    initial begin
        n_vec = 0; n_fail = 0;
        model_reset();
        for (int i = 0; i < int'(D); i++) ram[i] = '0;
        rst_n = 1'b0; m_ready = 1'b0; wptr_gray_sync = '0;

        // Reset held with random inputs
        repeat (4) begin
            @(negedge sync_clk);
            wptr_gray_sync = PW'($urandom);
            m_ready        = 1'($urandom);
            #1;
            chk("rst_m_valid", 64'(m_valid), 64'(0));
            chk("rst_m_data", 64'(m_data), 64'(0));
            chk("rst_rptr_gray", 64'(rptr_gray), 64'(0));
        end
        wptr_gray_sync = '0;
        #1;
        chk("rst_mem_ren", 64'(mem_ren), 64'(0));
        chk("rst_rd_count", 64'(rd_count), 64'(0));
        chk("rst_empty", 64'(empty), 64'(1));
        chk("rst_aempty", 64'(aempty), 64'(1));
        @(negedge sync_clk);
        rst_n = 1'b1;
        tick();

        // Single word
        push_val(32'hA5A5_0001);
        wsync = wtrue; m_ready = 1'b1;
        repeat (5) tick();

        // Streaming 16 words at full rate
        push_rand(16);
        wsync = wtrue;
        repeat (22) tick();

        // Backpressure with 8 words available
        m_ready = 1'b0;
        push_rand(8);
        wsync = wtrue;
        repeat (6) tick();
        chk("bp_rd_count", 64'(rd_count), 64'(6));
        chk("bp_m_data", 64'(m_data), 64'(data_q[delivered]));
        m_ready = 1'b1;
        repeat (12) tick();

        // Full RAM while stalled
        m_ready = 1'b0;
        push_rand(2);
        wsync = wtrue;
        repeat (4) tick();
        while (wtrue - issued < D) push_rand(1);
        wsync = wtrue;
        tick();
        chk("full_rd_count", 64'(rd_count), 64'(D));
        chk("full_aempty", 64'(aempty), 64'(0));
        m_ready = 1'b1;
        repeat (24) tick();

        // Random traffic with stale, multi-step pointer updates
        repeat (1500) begin
            m_ready = ($urandom_range(0, 3) != 0);
            push_rand($urandom_range(0, 2));
            wsync += $urandom_range(0, wtrue - wsync);
            tick();
        end
        m_ready = 1'b1;
        wsync = wtrue;
        repeat (40) tick();

        // Reset while one word is buffered and one read is in flight
        m_ready = 1'b0;
        push_rand(2);
        wsync = wtrue;
        repeat (2) tick();
        rst_n = 1'b0;
        model_reset();
        wptr_gray_sync = '0;
        #1;
        chk("midrst_m_valid", 64'(m_valid), 64'(0));
        chk("midrst_rptr_gray", 64'(rptr_gray), 64'(0));
        @(negedge sync_clk);
        rst_n = 1'b1;
        m_ready = 1'b1;
        repeat (8) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
